// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: DEPTH-entry in-order circular buffer of {inst, pc}, dropped wholesale on flush.
// Latency: an entry pushed at edge N is at the head from cycle N+1 (no bypass).
// Backpressure: in_ready depends only on occupancy (low when full), never on out_ready.
module if_id_queue #(
  parameter int                DEPTH    = 2,
  parameter int                INST_W   = 32,
  parameter int                PC_W     = 64,
  parameter logic [INST_W-1:0] NOP_INST = 'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_W-1:0]          in_inst,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_W-1:0]          out_inst,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Empty queue presents a harmless NOP so decode never sees stale storage.
  assign out_inst = out_valid ? inst_mem[rd_ptr] : NOP_INST;
  assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, single transfer, full/backpressure,
// simultaneous push/pop, flush and reset-while-full, each with hand-computed expectations.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  if_id_queue #(.DEPTH(2), .INST_W(32), .PC_W(64), .NOP_INST(32'h00000013)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'hdeadbeef; in_pc = 64'h1234;
    flush = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0; in_pc = 64'hffff_0000; in_inst = 32'hffffffff;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_inst !== 32'h00000013) begin n_bad++; $display("FAIL reset_out_inst got %h want 00000013", out_inst); end
    n_cmp++; if (out_pc !== 64'h0) begin n_bad++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_pc = 64'h8000_0000; in_inst = 32'h00100093; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_pc = 64'h0; in_inst = 32'h0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_out_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_pc !== 64'h8000_0000) begin n_bad++; $display("FAIL single_out_pc got %h want 80000000", out_pc); end
    n_cmp++; if (out_inst !== 32'h00100093) begin n_bad++; $display("FAIL single_out_inst got %h want 00100093", out_inst); end
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", count); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain_valid got %0b want 0", out_valid); end
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL single_drain_count got %0d want 0", count); end
    n_cmp++; if (out_inst !== 32'h00000013) begin n_bad++; $display("FAIL single_drain_inst got %h want 00000013", out_inst); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h8000_0000; in_inst = 32'h00000111;
    tick();
    in_pc = 64'h8000_0004; in_inst = 32'h00000222;
    tick();
    in_pc = 64'h8000_0008; in_inst = 32'h00000333;
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL full_count got %0d want 2", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
    tick();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL full_hold_count got %0d want 2", count); end
    n_cmp++; if (out_pc !== 64'h8000_0000) begin n_bad++; $display("FAIL full_head_pc got %h want 80000000", out_pc); end
    // Full with out_ready: pop only, the third push must wait a cycle.
    out_ready = 1'b1;
    tick();
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL full_pop_count got %0d want 1", count); end
    n_cmp++; if (out_pc !== 64'h8000_0004) begin n_bad++; $display("FAIL full_second_pc got %h want 80000004", out_pc); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_freed_in_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_pc !== 64'h8000_0008) begin n_bad++; $display("FAIL full_third_pc got %h want 80000008", out_pc); end
    n_cmp++; if (out_inst !== 32'h00000333) begin n_bad++; $display("FAIL full_third_inst got %h want 00000333", out_inst); end
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL full_third_count got %0d want 1", count); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h8000_0010; in_inst = 32'h0000aaaa;
    tick();
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL pp_setup_count got %0d want 1", count); end
    in_pc = 64'h8000_0014; in_inst = 32'h0000bbbb; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL pp_count got %0d want 1", count); end
    n_cmp++; if (out_pc !== 64'h8000_0014) begin n_bad++; $display("FAIL pp_out_pc got %h want 80000014", out_pc); end
    n_cmp++; if (out_inst !== 32'h0000bbbb) begin n_bad++; $display("FAIL pp_out_inst got %h want 0000bbbb", out_inst); end
    tick();
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL pp_drain_count got %0d want 0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h8000_0020; in_inst = 32'h00000c01;
    tick();
    in_pc = 64'h8000_0024; in_inst = 32'h00000c02;
    tick();
    in_pc = 64'h8000_0028; in_inst = 32'h00000c03;
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    in_pc = 64'h8000_0100; in_inst = 32'h00000d00;
    tick();
    n_cmp++; if (out_pc !== 64'h8000_0100) begin n_bad++; $display("FAIL flush_new_head_pc got %h want 80000100", out_pc); end
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL flush_new_count got %0d want 1", count); end
    // Flush with room available: the concurrent push is discarded too.
    in_pc = 64'h8000_0104; in_inst = 32'h00000d04; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL flush_push_drop_count got %0d want 0", count); end
    in_pc = 64'h8000_0108; in_inst = 32'h00000d08;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_pc !== 64'h8000_0108) begin n_bad++; $display("FAIL flush_after_pc got %h want 80000108", out_pc); end
    n_cmp++; if (out_inst !== 32'h00000d08) begin n_bad++; $display("FAIL flush_after_inst got %h want 00000d08", out_inst); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h8000_0200; in_inst = 32'h00000e00;
    tick();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL rfull_setup_count got %0d want 2", count); end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rfull_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_inst !== 32'h00000013) begin n_bad++; $display("FAIL rfull_out_inst got %h want 00000013", out_inst); end
    n_cmp++; if (out_pc !== 64'h0) begin n_bad++; $display("FAIL rfull_out_pc got %h want 0", out_pc); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rfull_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL rfull_count got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_push_pop();
    test_flush();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
